// File: rtl/one2sig_serial.sv
// Unpacks one N-lane packed word into N sign-extended samples, lane 0 first,
// under a valid/ready handshake; done pulses once after the last lane transfers.
module one2sig_serial #(
   parameter  int W     = 10,
   parameter  int N     = 16,
   parameter  int OUT_W = 16,
   localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk_fast,
   input  logic             rst_n,
   input  logic [N*W-1:0]   Sin_s,
   input  logic             split_sig_s,
   output logic             in_rdy,
   output logic [OUT_W-1:0] Sout,
   output logic [IW-1:0]    Sout_idx,
   output logic             Sout_vld,
   input  logic             Sout_rdy,
   output logic             done
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state_q;
   logic [N*W-1:0]     shreg_q;
   logic [OUT_W-1:0]   sout_q;
   logic [IW-1:0]      idx_q;
   logic               vld_q;
   logic               done_q;

   logic [W-1:0]       load_lane_d;
   logic [W-1:0]       next_lane_d;
   logic               last_d;

   function automatic logic [OUT_W-1:0] sext(input logic [W-1:0] lane);
      logic signed [OUT_W-1:0] r;
      r = $signed(lane);
      return r;
   endfunction

   // Lane 1 of the current shift contents becomes the next sample on a beat.
   assign load_lane_d = Sin_s[W-1:0];
   assign next_lane_d = shreg_q[2*W-1:W];
   assign last_d      = (idx_q == IW'(N-1));

   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         sout_q  <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (split_sig_s) begin
                  shreg_q <= Sin_s;
                  sout_q  <= sext(load_lane_d);
                  idx_q   <= '0;
                  vld_q   <= 1'b1;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (Sout_rdy) begin
                  if (last_d) begin
                     vld_q   <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     shreg_q <= shreg_q >> W;
                     sout_q  <= sext(next_lane_d);
                     idx_q   <= idx_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_rdy   = (state_q == IDLE);
   assign Sout     = sout_q;
   assign Sout_idx = idx_q;
   assign Sout_vld = vld_q;
   assign done     = done_q;

endmodule
